// File: rtl/hcsr04_pkg.sv
// Shared types and range limits for the HC-SR04 distance filter.
package hcsr04_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int MAX_RANGE_CM = 400;
    localparam int MIN_RANGE_CM = 1;

    function automatic logic in_range(input logic [8:0] d);
        return (int'(d) >= MIN_RANGE_CM) && (int'(d) <= MAX_RANGE_CM);
    endfunction

endpackage

// File: rtl/hcsr04_dist_filter_if.sv
// Sample/result bundle between the ranging front end and the distance filter.
interface hcsr04_dist_filter_if #(
    parameter int DEPTH = 4
);
    logic                     enable;
    logic [8:0]               dist_in;
    logic                     dist_valid;
    logic [8:0]               threshold;
    logic [8:0]               avg_out;
    logic                     avg_valid;
    logic                     near_alarm;
    logic                     stale;
    logic [$clog2(DEPTH):0]   fill_level;

    modport master (
        output enable, dist_in, dist_valid, threshold,
        input  avg_out, avg_valid, near_alarm, stale, fill_level
    );

    modport slave (
        input  enable, dist_in, dist_valid, threshold,
        output avg_out, avg_valid, near_alarm, stale, fill_level
    );
endinterface

// File: rtl/hcsr04_win_sum.sv
// Circular sample window with running sum; exposes the post-write sum so the
// caller can register the mean in the same edge that stores the sample.
module hcsr04_win_sum #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int SW    = 9 + PW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic          full,
    input  logic [8:0]    din,
    output logic [SW-1:0] sum_nxt_o
);

    logic [8:0]    buf_q [DEPTH];
    logic [PW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [8:0]    evicted;

    // When full the write pointer sits on the oldest entry, which is the one evicted.
    assign evicted = full ? buf_q[ptr_q] : 9'd0;

    always_comb begin
        ptr_d = ptr_q;
        sum_d = sum_q;
        if (clr) begin
            ptr_d = '0;
            sum_d = '0;
        end else if (wr_en) begin
            ptr_d = ptr_q + PW'(1);
            sum_d = sum_q + SW'(din) - SW'(evicted);
        end
    end

    assign sum_nxt_o = sum_d;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr_q <= '0;
            sum_q <= '0;
            for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
        end else begin
            ptr_q <= ptr_d;
            sum_q <= sum_d;
            if (wr_en) buf_q[ptr_q] <= din;
        end
    end

endmodule

// File: rtl/hcsr04_dist_filter.sv
// Windowed-mean distance filter with near alarm and sample timeout.
// Optional outlier rejection (0 cm or beyond range) via HCSR04_FILT_OUTLIER_EN.
module hcsr04_dist_filter
    import hcsr04_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HYST_CM     = 5,
    parameter int TIMEOUT_CYC = 10_000_000
) (
    input  logic PCLK,
    input  logic PRESET,
    hcsr04_dist_filter_if.slave bus
);

    localparam int L  = $clog2(DEPTH);
    localparam int FW = L + 1;
    localparam int SW = 9 + L;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        state_q, state_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [8:0]    avg_q, avg_d;
    logic          avg_valid_q, avg_valid_d;
    logic          near_q, near_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic          sample_ok;
    logic          accept;
    logic          update;
    logic [SW-1:0] sum_nxt;
    logic [8:0]    avg_nxt;
    logic [9:0]    release_lvl;

`ifdef HCSR04_FILT_OUTLIER_EN
    assign sample_ok = in_range(bus.dist_in);
`else
    assign sample_ok = 1'b1;
`endif

    assign accept      = bus.dist_valid && bus.enable && sample_ok;
    assign update      = accept && ((state_q == FULL) ||
                                    ((state_q == FILL) && (fill_q == FW'(DEPTH - 1))));
    assign avg_nxt     = 9'(sum_nxt >> L);
    assign release_lvl = {1'b0, bus.threshold} + 10'(HYST_CM);

    hcsr04_win_sum #(.DEPTH(DEPTH)) u_win (
        .clk       (PCLK),
        .rst       (PRESET),
        .clr       (!bus.enable),
        .wr_en     (accept),
        .full      (state_q == FULL),
        .din       (bus.dist_in),
        .sum_nxt_o (sum_nxt)
    );

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        near_d      = near_q;
        tmo_d       = tmo_q;
        if (!bus.enable) begin
            state_d = EMPTY;
            fill_d  = '0;
            near_d  = 1'b0;
            tmo_d   = '0;
        end else begin
            if (accept) begin
                unique case (state_q)
                    EMPTY: begin
                        state_d = FILL;
                        fill_d  = FW'(1);
                    end
                    FILL: begin
                        fill_d = fill_q + FW'(1);
                        if (fill_q == FW'(DEPTH - 1)) state_d = FULL;
                    end
                    FULL:    state_d = FULL;
                    default: state_d = EMPTY;
                endcase
            end
            if (update) begin
                avg_d       = avg_nxt;
                avg_valid_d = 1'b1;
                if (avg_nxt < bus.threshold)             near_d = 1'b1;
                else if ({1'b0, avg_nxt} >= release_lvl) near_d = 1'b0;
            end
            if (accept)                        tmo_d = '0;
            else if (tmo_q != TW'(TIMEOUT_CYC)) tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= EMPTY;
            fill_q      <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            near_q      <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            near_q      <= near_d;
            tmo_q       <= tmo_d;
        end
    end

    assign bus.avg_out    = avg_q;
    assign bus.avg_valid  = avg_valid_q;
    assign bus.near_alarm = near_q;
    assign bus.stale      = (tmo_q == TW'(TIMEOUT_CYC));
    assign bus.fill_level = fill_q;

endmodule

// File: tb/tb_hcsr04_dist_filter.sv
// Directed bench for hcsr04_dist_filter: DEPTH=4, HYST_CM=5, TIMEOUT_CYC=50.
module tb_hcsr04_dist_filter;

    logic PCLK = 1'b0;
    logic PRESET;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 PCLK = ~PCLK;

    hcsr04_dist_filter_if #(.DEPTH(4)) bus ();

    hcsr04_dist_filter #(.DEPTH(4), .HYST_CM(5), .TIMEOUT_CYC(50)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    // Drive one strobe; returns at the falling edge after the accepting edge.
    task automatic send(input logic [8:0] d);
        @(negedge PCLK);
        bus.dist_in    = d;
        bus.dist_valid = 1'b1;
        @(negedge PCLK);
        bus.dist_valid = 1'b0;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        bus.enable = 1'b0;
        bus.dist_valid = 1'b0;
        bus.dist_in = '0;
        bus.threshold = 9'd70;
        repeat (2) @(negedge PCLK);
        n_total++; if (bus.avg_out !== 9'd0) $display("FAIL reset_avg got=%0d exp=0", bus.avg_out); else n_pass++;
        n_total++; if (bus.avg_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus.avg_valid); else n_pass++;
        n_total++; if (bus.near_alarm !== 1'b0) $display("FAIL reset_near got=%b exp=0", bus.near_alarm); else n_pass++;
        n_total++; if (bus.stale !== 1'b0) $display("FAIL reset_stale got=%b exp=0", bus.stale); else n_pass++;
        n_total++; if (bus.fill_level !== 3'd0) $display("FAIL reset_fill got=%0d exp=0", bus.fill_level); else n_pass++;
        PRESET = 1'b0;
        bus.enable = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 3; i++) begin
            send(9'd100);
            n_total++; if (bus.avg_valid !== 1'b0) $display("FAIL fill_novalid_%0d got=%b exp=0", i, bus.avg_valid); else n_pass++;
            n_total++; if (bus.fill_level !== 3'(i)) $display("FAIL fill_level_%0d got=%0d exp=%0d", i, bus.fill_level, i); else n_pass++;
        end
        send(9'd100);
        n_total++; if (bus.avg_valid !== 1'b1) $display("FAIL fill_valid got=%b exp=1", bus.avg_valid); else n_pass++;
        n_total++; if (bus.avg_out !== 9'd100) $display("FAIL fill_avg got=%0d exp=100", bus.avg_out); else n_pass++;
        n_total++; if (bus.fill_level !== 3'd4) $display("FAIL fill_full got=%0d exp=4", bus.fill_level); else n_pass++;
        n_total++; if (bus.near_alarm !== 1'b0) $display("FAIL fill_near got=%b exp=0", bus.near_alarm); else n_pass++;
        @(negedge PCLK);
        n_total++; if (bus.avg_valid !== 1'b0) $display("FAIL fill_pulse got=%b exp=0", bus.avg_valid); else n_pass++;
        n_total++; if (bus.avg_out !== 9'd100) $display("FAIL fill_hold got=%0d exp=100", bus.avg_out); else n_pass++;
    endtask

    task automatic test_slide();
        send(9'd20);
        n_total++; if (bus.avg_out !== 9'd80) $display("FAIL slide_80 got=%0d exp=80", bus.avg_out); else n_pass++;
        n_total++; if (bus.near_alarm !== 1'b0) $display("FAIL slide_near80 got=%b exp=0", bus.near_alarm); else n_pass++;
        send(9'd20);
        n_total++; if (bus.avg_out !== 9'd60) $display("FAIL slide_60 got=%0d exp=60", bus.avg_out); else n_pass++;
        n_total++; if (bus.near_alarm !== 1'b1) $display("FAIL slide_near60 got=%b exp=1", bus.near_alarm); else n_pass++;
    endtask

    task automatic test_hysteresis();
        send(9'd148);
        n_total++; if (bus.avg_out !== 9'd72) $display("FAIL hyst_72 got=%0d exp=72", bus.avg_out); else n_pass++;
        n_total++; if (bus.near_alarm !== 1'b1) $display("FAIL hyst_hold got=%b exp=1", bus.near_alarm); else n_pass++;
        send(9'd112);
        n_total++; if (bus.avg_out !== 9'd75) $display("FAIL hyst_75 got=%0d exp=75", bus.avg_out); else n_pass++;
        n_total++; if (bus.near_alarm !== 1'b0) $display("FAIL hyst_clear got=%b exp=0", bus.near_alarm); else n_pass++;
        send(9'd23);
        n_total++; if (bus.avg_out !== 9'd75) $display("FAIL hyst_trunc got=%0d exp=75", bus.avg_out); else n_pass++;
    endtask

    task automatic test_timeout();
        repeat (49) @(negedge PCLK);
        n_total++; if (bus.stale !== 1'b0) $display("FAIL tmo_49 got=%b exp=0", bus.stale); else n_pass++;
        @(negedge PCLK);
        n_total++; if (bus.stale !== 1'b1) $display("FAIL tmo_50 got=%b exp=1", bus.stale); else n_pass++;
        repeat (5) @(negedge PCLK);
        n_total++; if (bus.stale !== 1'b1) $display("FAIL tmo_sat got=%b exp=1", bus.stale); else n_pass++;
        send(9'd20);
        n_total++; if (bus.stale !== 1'b0) $display("FAIL tmo_clear got=%b exp=0", bus.stale); else n_pass++;
        n_total++; if (bus.avg_out !== 9'd75) $display("FAIL tmo_avg got=%0d exp=75", bus.avg_out); else n_pass++;
    endtask

    task automatic test_disable();
        bus.threshold = 9'd200;
        send(9'd100);
        n_total++; if (bus.avg_out !== 9'd63) $display("FAIL dis_avg63 got=%0d exp=63", bus.avg_out); else n_pass++;
        n_total++; if (bus.near_alarm !== 1'b1) $display("FAIL dis_near_set got=%b exp=1", bus.near_alarm); else n_pass++;
        bus.enable = 1'b0;
        bus.dist_in = 9'd300;
        bus.dist_valid = 1'b1;
        @(negedge PCLK);
        bus.dist_valid = 1'b0;
        n_total++; if (bus.fill_level !== 3'd0) $display("FAIL dis_fill got=%0d exp=0", bus.fill_level); else n_pass++;
        n_total++; if (bus.near_alarm !== 1'b0) $display("FAIL dis_near got=%b exp=0", bus.near_alarm); else n_pass++;
        n_total++; if (bus.avg_out !== 9'd63) $display("FAIL dis_hold got=%0d exp=63", bus.avg_out); else n_pass++;
        n_total++; if (bus.avg_valid !== 1'b0) $display("FAIL dis_valid got=%b exp=0", bus.avg_valid); else n_pass++;
        bus.enable = 1'b1;
    endtask

    task automatic test_reject();
        logic [2:0] exp_f0, exp_f1, exp_f3;
        logic       exp_v;
        logic [8:0] exp_avg;
`ifdef HCSR04_FILT_OUTLIER_EN
        exp_f0 = 3'd0; exp_f1 = 3'd0; exp_f3 = 3'd2; exp_v = 1'b0; exp_avg = 9'd63;
`else
        exp_f0 = 3'd1; exp_f1 = 3'd2; exp_f3 = 3'd4; exp_v = 1'b1; exp_avg = 9'd117;
`endif
        send(9'd0);
        n_total++; if (bus.fill_level !== exp_f0) $display("FAIL rej_zero got=%0d exp=%0d", bus.fill_level, exp_f0); else n_pass++;
        send(9'd450);
        n_total++; if (bus.fill_level !== exp_f1) $display("FAIL rej_450 got=%0d exp=%0d", bus.fill_level, exp_f1); else n_pass++;
        send(9'd10);
        send(9'd10);
        n_total++; if (bus.fill_level !== exp_f3) $display("FAIL rej_fill got=%0d exp=%0d", bus.fill_level, exp_f3); else n_pass++;
        n_total++; if (bus.avg_valid !== exp_v) $display("FAIL rej_valid got=%b exp=%b", bus.avg_valid, exp_v); else n_pass++;
        n_total++; if (bus.avg_out !== exp_avg) $display("FAIL rej_avg got=%0d exp=%0d", bus.avg_out, exp_avg); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bus.enable = 1'b0;
        @(negedge PCLK);
        bus.enable = 1'b1;
        send(9'd50);
        send(9'd50);
        n_total++; if (bus.fill_level !== 3'd2) $display("FAIL rst_pre_fill got=%0d exp=2", bus.fill_level); else n_pass++;
        PRESET = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        n_total++; if (bus.avg_out !== 9'd0) $display("FAIL rst_avg got=%0d exp=0", bus.avg_out); else n_pass++;
        n_total++; if (bus.fill_level !== 3'd0) $display("FAIL rst_fill got=%0d exp=0", bus.fill_level); else n_pass++;
        n_total++; if (bus.near_alarm !== 1'b0) $display("FAIL rst_near got=%b exp=0", bus.near_alarm); else n_pass++;
        n_total++; if (bus.stale !== 1'b0) $display("FAIL rst_stale got=%b exp=0", bus.stale); else n_pass++;
        for (int i = 1; i <= 3; i++) begin
            send(9'd8);
            n_total++; if (bus.avg_valid !== 1'b0) $display("FAIL rst_refill_%0d got=%b exp=0", i, bus.avg_valid); else n_pass++;
        end
        send(9'd8);
        n_total++; if (bus.avg_valid !== 1'b1) $display("FAIL rst_valid got=%b exp=1", bus.avg_valid); else n_pass++;
        n_total++; if (bus.avg_out !== 9'd8) $display("FAIL rst_avg8 got=%0d exp=8", bus.avg_out); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_slide();
        test_hysteresis();
        test_timeout();
        test_disable();
        test_reject();
        test_reset_mid();
        repeat (2) @(negedge PCLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hcsr04_dist_filter.md
HCSR04_DIST_FILTER -- requirements
Module: hcsr04_dist_filter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, window length in samples (power of 2, 2..16).
REQ-002 SHALL have parameter HYST_CM, default 5, alarm release hysteresis in cm.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 10_000_000, PCLK cycles without an accepted sample before stale is set.
REQ-004 SHALL have one clock, PCLK, input, 1 bit; all state changes on its rising edge.
REQ-005 SHALL have reset PRESET, input, 1 bit, synchronous and active-high.
REQ-006 SHALL have enable, input, 1 bit: filter run enable.
REQ-007 SHALL have dist_in, input, 9 bits: measured distance in cm.
REQ-008 SHALL have dist_valid, input, 1 bit: single-cycle strobe qualifying dist_in (the measurement-done pulse).
REQ-009 SHALL have threshold, input, 9 bits: near-alarm set level in cm.
REQ-010 SHALL have avg_out, output, 9 bits: windowed mean distance.
REQ-011 SHALL have avg_valid, output, 1 bit: single-cycle pulse on each avg_out update.
REQ-012 SHALL have near_alarm, output, 1 bit: object-near flag.
REQ-013 SHALL have stale, output, 1 bit: sample timeout flag.
REQ-014 SHALL have fill_level, output, $clog2(DEPTH)+1 bits: number of valid window entries.

Function
REQ-015 SHALL accept a sample when dist_valid=1 and enable=1 and the sample passes the reject rule (REQ-031); otherwise the sample is dropped with no state change.
REQ-016 SHALL store accepted samples in a DEPTH-entry circular buffer; the write pointer wraps from DEPTH-1 to 0.
REQ-017 SHALL keep a running sum of width 9+$clog2(DEPTH) with no overflow: sum_next = sum + new - evicted, where evicted is 0 while not FULL.
REQ-018 SHALL use an FSM with states EMPTY (fill_level=0), FILL (0<fill_level<DEPTH) and FULL (fill_level=DEPTH): EMPTY->FILL on the first accept; FILL->FULL on the accept that reaches DEPTH; FULL stays FULL; any state goes to EMPTY when enable=0.
REQ-019 SHALL set avg_out = sum >> $clog2(DEPTH) (truncating) one cycle after an accept made while FULL or on the FILL->FULL transition, and pulse avg_valid in that same cycle.
REQ-020 SHALL hold avg_out between updates.
REQ-021 SHALL not pulse avg_valid in EMPTY or FILL.
REQ-022 SHALL set near_alarm on the avg_valid cycle when avg_out < threshold.
REQ-023 SHALL clear near_alarm on the avg_valid cycle when avg_out >= threshold + HYST_CM, computed at 10 bits with no wrap.
REQ-024 SHALL otherwise hold near_alarm.
REQ-025 SHALL count PCLK cycles since the last accept with a saturating counter; stale=1 when the count reaches TIMEOUT_CYC.
REQ-026 SHALL clear the timeout count and stale in the cycle after an accept.
REQ-027 SHALL, while enable=0, clear the buffer, sum, fill_level, near_alarm, stale and the timeout count, hold avg_out, and force avg_valid=0.
REQ-028 SHALL drop a sample whose dist_valid coincides with enable=0.

Reset
REQ-029 SHALL, on PRESET=1 at a PCLK edge, set the FSM to EMPTY and zero avg_out, avg_valid, near_alarm, stale, fill_level, sum, pointers and the timeout count.
REQ-030 SHALL, when PRESET is asserted mid-fill or mid-run, discard all samples; no avg_valid pulse occurs until DEPTH new accepts.

Configuration
REQ-031 SHALL support macro HCSR04_FILT_OUTLIER_EN: when defined, samples with dist_in=0 or dist_in>400 are rejected (no accept, timeout count not cleared); when undefined, every dist_valid sample with enable=1 is accepted.

Structure
REQ-032 SHALL place the FSM state enum (EMPTY/FILL/FULL) and constants MAX_RANGE_CM=400 and MIN_RANGE_CM=1 in shared package hcsr04_pkg.
REQ-033 SHALL implement the buffer, pointer and running sum as a sub-module hcsr04_win_sum; the FSM, alarm and timeout logic live in the top module.

Verification
REQ-034 SHALL cover fill: enable=1, DEPTH=4, samples 100,100,100,100 -> no avg_valid after the first three; avg_valid one cycle after the fourth with avg_out=100, fill_level=4.
REQ-035 SHALL cover slide: next samples 20,20 -> avg_out=80 then 60; with threshold=70, near_alarm=1 at the 60 update.
REQ-036 SHALL cover hysteresis: threshold=70, near_alarm=1, window averages 72 then 75 -> near_alarm stays 1 at 72 and clears at 75.
REQ-037 SHALL cover timeout: TIMEOUT_CYC=50, no dist_valid for 50 cycles -> stale=1; one accept -> stale=0 the next cycle.
REQ-038 SHALL cover reject: with HCSR04_FILT_OUTLIER_EN, dist_in=0 and dist_in=450 -> fill_level unchanged; without the macro, both are accepted.
REQ-039 SHALL cover disable/reset mid-run: enable drops while FULL -> fill_level=0 and near_alarm=0 next cycle, avg_out held; PRESET during FILL -> all outputs 0.
